// File: rtl/mul_div_pkg.sv
// Shared definitions for the EX-stage multiply/divide path.
package mul_div_pkg;

  // Iterations of the radix-2 divider for the default 32-bit datapath.
  localparam int unsigned DIV_CYCLES = 32;

  // Quotient returned on divide by zero. The divider truncates it to its own width.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  // Divider control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step on the packed {R, Q} working register.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH:0]   rq_i,
  input  logic [WIDTH-1:0]   div_i,
  output logic [2*WIDTH:0]   rq_o
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;
  logic             ge;

  // Shift {R,Q} left, then subtract the divisor from R if it fits.
  // R stays below the divisor between steps, so its MSB is always zero on entry;
  // it is folded into the compare so an unexpected value still forces a subtract.
  always_comb begin
    shifted = {rq_i[2*WIDTH-1:0], 1'b0};
    r_sh    = shifted[2*WIDTH:WIDTH];
    r_sub   = r_sh - {1'b0, div_i};
    ge      = rq_i[2*WIDTH] | (r_sh >= {1'b0, div_i});
    rq_o    = shifted;
    if (ge) begin
      rq_o = {r_sub, shifted[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative unsigned restoring divider; stalls the pipeline while busy.
module div_iter
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_CYCLES,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stallreq,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned RQ_W = 2 * WIDTH + 1;

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RQ_W-1:0]  work_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             out_valid_q;
  logic [RQ_W-1:0]  step_d;
  logic             start_c;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rq_i  (work_q),
    .div_i (div_q),
    .rq_o  (step_d)
  );

  assign start_c   = in_valid & ~cancel;
  assign stallreq  = ((state_q == S_IDLE) & start_c) | (state_q == S_CALC);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_c) begin
            div_q <= b;
            if (b == '0) begin
              quotient_q  <= WIDTH'(DIV0_QUOTIENT);
              remainder_q <= a;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              work_q  <= {{(WIDTH + 1){1'b0}}, a};
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (cancel) begin
            state_q <= S_IDLE;
          end else begin
            work_q <= step_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
              quotient_q  <= step_d[WIDTH-1:0];
              remainder_q <= step_d[2*WIDTH-1:WIDTH];
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: latency, stall window, results, cancel and reset.
module tb_div_iter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        stallreq;
  logic        out_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int          n_checks;
  int          n_pass;
  int          valid_cnt;
  logic [63:0] expq[$];

  div_iter dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .cancel    (cancel),
    .a         (a),
    .b         (b),
    .stallreq  (stallreq),
    .out_valid (out_valid),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] av, input logic [31:0] bv);
    if (bv == 32'd0) return {32'hFFFF_FFFF, av};
    return {av / bv, av % bv};
  endfunction

  // Result monitor: every out_valid pops one expected result.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      logic [63:0] e;
      valid_cnt++;
      if (expq.size() == 0) begin
        check_eq("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = expq.pop_front();
        check_eq("quotient", {32'd0, quotient}, {32'd0, e[63:32]});
        check_eq("remainder", {32'd0, remainder}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    cancel   = 1'b0;
    a        = av;
    b        = bv;
    expq.push_back(model(av, bv));
  endtask

  // Starts an op and waits (bounded) for out_valid; returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv);
    int cyc;
    int stall_cnt;
    int done_cyc;
    int exp_lat;
    exp_lat   = (bv == 32'd0) ? 1 : 33;
    cyc       = 0;
    stall_cnt = 0;
    done_cyc  = -1;
    start_op(av, bv);
    while (cyc < 100 && done_cyc < 0) begin
      @(negedge clk);
      if (stallreq) stall_cnt++;
      if (out_valid) done_cyc = cyc;
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(done_cyc), 64'(exp_lat));
    check_eq({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_lat));
  endtask

  task automatic go_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cancel   = 1'b0;
    end
  endtask

  initial begin
    int v0;
    int s_cnt;
    n_checks  = 0;
    n_pass    = 0;
    valid_cnt = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    cancel    = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_quotient", {32'd0, quotient}, 64'd0);
    check_eq("rst_remainder", {32'd0, remainder}, 64'd0);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_stallreq", {63'd0, stallreq}, 64'd0);
    reset = 1'b1;
    go_idle(2);

    // Basic division
    run_op("t1", 32'd100, 32'd7);
    go_idle(2);

    // Max dividend, then back-to-back small op
    run_op("t2a", 32'hFFFF_FFFF, 32'd1);
    run_op("t2b", 32'd3, 32'd10);
    go_idle(2);

    // Divide by zero
    run_op("t3", 32'd5, 32'd0);
    go_idle(2);

    // Cancel mid-operation
    v0 = valid_cnt;
    start_op(32'd1000, 32'd3);
    void'(expq.pop_back());
    repeat (10) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(negedge clk);
    check_eq("t4_stall_c10", {63'd0, stallreq}, 64'd1);
    @(posedge clk);
    #1;
    cancel   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_idle_c11", {63'd0, stallreq}, 64'd0);
    repeat (40) @(negedge clk);
    check_eq("t4_no_valid", 64'(valid_cnt - v0), 64'd0);
    check_eq("t4_keep_q", {32'd0, quotient}, 64'hFFFF_FFFF);
    check_eq("t4_keep_r", {32'd0, remainder}, 64'd5);
    run_op("t4b", 32'd20, 32'd4);
    go_idle(2);

    // Reset mid-operation
    v0 = valid_cnt;
    start_op(32'h8000_0000, 32'h8000_0001);
    void'(expq.pop_back());
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_eq("t5_rst_q", {32'd0, quotient}, 64'd0);
    check_eq("t5_rst_r", {32'd0, remainder}, 64'd0);
    check_eq("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b0;
    #1;
    check_eq("t5_rst_stall", {63'd0, stallreq}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_eq("t5_no_valid", 64'(valid_cnt - v0), 64'd0);
    run_op("t5b", 32'h8000_0001, 32'h8000_0000);
    go_idle(2);

    // in_valid together with cancel in IDLE never starts
    v0    = valid_cnt;
    s_cnt = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    cancel   = 1'b1;
    a        = 32'd7;
    b        = 32'd2;
    repeat (40) begin
      @(negedge clk);
      if (stallreq) s_cnt++;
    end
    check_eq("t6_stall", 64'(s_cnt), 64'd0);
    check_eq("t6_no_valid", 64'(valid_cnt - v0), 64'd0);
    go_idle(2);
    check_eq("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative unsigned radix-2 restoring divider for the EX-stage multiply/divide path.
- Sits directly downstream of the operand lock stage. It consumes the locked, sign-stripped operands and a locked divide-enable, and raises a stall request while it is busy.
- Produces the unsigned quotient and remainder for the result mux, which re-applies the sign.
- Signed handling is entirely outside this block.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserted (0) forces all state to reset values immediately.
- in_valid  input  1  locked divide enable. Held high by the lock stage for the whole stall.
- cancel  input  1  pipeline flush. Aborts any operation in progress.
- a  input  WIDTH  dividend, unsigned, locked.
- b  input  WIDTH  divisor, unsigned, locked.
- stallreq  output  1  combinational request to stall the pipeline.
- out_valid  output  1  one-cycle pulse when quotient and remainder are valid.
- quotient  output  WIDTH  registered quotient.
- remainder  output  WIDTH  registered remainder.

Behaviour:

States and transitions:
- States are IDLE, CALC and DONE.
- IDLE: if in_valid & ~cancel, capture a and b.
  - If b==0, go to DONE.
  - Otherwise load the working register with {WIDTH+1 zeros, a}, set cnt=0 and go to CALC.
- CALC: perform one restoring step per cycle.
  - Shift {R,Q} left by one.
  - If R[WIDTH:0] >= {1'b0,b}, set R = R - b and Q[0]=1; otherwise Q[0]=0.
  - Increment cnt. After the step where cnt==WIDTH-1, go to DONE.
- DONE: out_valid=1; quotient and remainder are loaded on entry to DONE. Unconditionally return to IDLE. in_valid is ignored in DONE, because the lock stage is still showing the finished op.

Stall request:
- stallreq = (IDLE & in_valid & ~cancel) | CALC.
- stallreq is 0 in DONE, so the pipeline advances in the out_valid cycle.

Latency (b != 0), with cycle 0 = IDLE and in_valid seen:
- CALC occupies cycles 1..WIDTH.
- DONE (out_valid) occurs in cycle WIDTH+1, i.e. 33 for WIDTH=32.
- stallreq is high for cycles 0..WIDTH.

Divide by zero:
- quotient = all ones, remainder = a.
- out_valid in cycle 1; stallreq high only in cycle 0.

Result registers:
- quotient and remainder hold their value until the next completed operation.
- They are not cleared by cancel.

Cancel:
- cancel in CALC or DONE: go to IDLE next edge. No out_valid; output registers are unchanged.
- cancel and in_valid together in IDLE: no start, stallreq=0.

Back-to-back operations:
- A new op may start in the IDLE cycle immediately after DONE.

Reset values:
- state=IDLE, cnt=0, working register=0, quotient=0, remainder=0, out_valid=0.
- stallreq follows its IDLE equation.
- Reset mid-operation aborts without out_valid.

Width rules:
- Partial remainder is WIDTH+1 bits, so the compare/subtract never overflows.
- The final remainder is the low WIDTH bits of R.

Decomposition:
- Shared package (mul_div_pkg):
  - state encoding localparams S_IDLE, S_CALC, S_DONE;
  - DIV_CYCLES = WIDTH;
  - DIV0_QUOTIENT = all-ones constant.
- One natural sub-module: div_step. It is combinational: it takes {R,Q} and b and returns the next {R,Q}, so the iteration logic can be swapped for a radix-4 version later.

Test Plan:
1. a=100, b=7, in_valid held until out_valid. Expect:
   - stallreq high for cycles 0..32;
   - out_valid in cycle 33;
   - quotient=14, remainder=2.
2. a=0xFFFFFFFF, b=1 → quotient=0xFFFFFFFF, remainder=0 in cycle 33. Then a=3, b=10 starts in the next IDLE cycle → quotient=0, remainder=3 at its cycle 33.
3. a=5, b=0 → stallreq only in cycle 0, out_valid in cycle 1, quotient=0xFFFFFFFF, remainder=5.
4. a=1000, b=3 started, cancel pulsed at cycle 10. Expect:
   - return to IDLE at cycle 11;
   - no out_valid;
   - outputs retain the previous result.
   Then a=20, b=4 → quotient=5, remainder=0 at cycle 33.
5. a=0x80000000, b=0x80000001 started, reset asserted at cycle 15. Expect:
   - immediate IDLE;
   - quotient=remainder=0, out_valid=0.
   After release, a=0x80000001, b=0x80000000 → quotient=1, remainder=1.
6. in_valid and cancel both high in IDLE → stallreq=0, no start, and no out_valid over 40 cycles.
